// File: rtl/mem_stage_ls.sv
// Load/store memory stage: pass-through of ALU results, single outstanding data-memory
// access with lane steering, load extension, misalign detection, bus timeout and flush.
//
// state | meaning
// IDLE  | ready for a new EX result; ALU results and misaligned ops complete in one cycle
// BUSY  | data-memory request outstanding; waits for dm_ack or timeout
module mem_stage_ls #(
    parameter int AW     = 32,
    parameter int RAW    = 5,
    parameter int TO_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            flush_i,
    input  logic [31:0]     wdata_i,
    input  logic [RAW-1:0]  wd_i,
    input  logic            wreg_i,
    input  logic [3:0]      mem_op_i,
    input  logic [AW-1:0]   mem_addr_i,
    input  logic [31:0]     mem_sdata_i,
    output logic            dm_req,
    output logic            dm_we,
    output logic [AW-1:0]   dm_addr,
    output logic [3:0]      dm_be,
    output logic [31:0]     dm_wdata,
    input  logic            dm_ack,
    input  logic [31:0]     dm_rdata,
    output logic            valid_o,
    output logic            wreg_o,
    output logic [RAW-1:0]  wd_o,
    output logic [31:0]     wdata_o,
    output logic            misalign_o,
    output logic            bus_err_o,
    output logic            stall_req_o
);

    localparam int CW = $clog2(TO_CYC + 1);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state, state_nxt;
    logic            is_mem, is_store, misal;
    logic            accept, start_bus, ack_done, to_done, done, flushed;
    logic [3:0]      st_be;
    logic [31:0]     st_wdata;
    logic [3:0]      lat_op;
    logic [1:0]      lat_lane;
    logic [RAW-1:0]  lat_wd;
    logic            lat_wreg;
    logic            lat_is_load;
    logic            flush_mem;
    logic [CW-1:0]   cnt, cnt_inc;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_data;
    logic            valid_nxt, wreg_nxt, mis_nxt, berr_nxt;
    logic [RAW-1:0]  wd_nxt;
    logic [31:0]     wdata_nxt;

    assign ready_o     = (state == IDLE);
    assign stall_req_o = (state == BUSY);

    always_comb begin
        is_mem   = (mem_op_i >= OP_LB) && (mem_op_i <= OP_SW);
        is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
        case (mem_op_i)
            OP_LH, OP_LHU, OP_SH: misal = mem_addr_i[0];
            OP_LW, OP_SW:         misal = |mem_addr_i[1:0];
            default:              misal = 1'b0;
        endcase
        case (mem_op_i)
            OP_SB: begin
                st_be    = 4'b0001 << mem_addr_i[1:0];
                st_wdata = {4{mem_sdata_i[7:0]}};
            end
            OP_SH: begin
                st_be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{mem_sdata_i[15:0]}};
            end
            OP_SW: begin
                st_be    = 4'b1111;
                st_wdata = mem_sdata_i;
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = 32'd0;
            end
        endcase
    end

    assign accept    = (state == IDLE) && valid_i && !flush_i;
    assign start_bus = accept && is_mem && !misal;
    assign cnt_inc   = cnt + CW'(1);
    assign ack_done  = (state == BUSY) && dm_ack;
    // ack beats a timeout landing on the same edge
    assign to_done   = (state == BUSY) && !dm_ack && (cnt_inc == CW'(TO_CYC));
    assign done      = ack_done || to_done;
    assign flushed   = flush_mem || flush_i;
    assign lat_is_load = (lat_op <= OP_LW);

    always_comb begin
        ld_byte = dm_rdata[{lat_lane, 3'b000} +: 8];
        ld_half = lat_lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (lat_op)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'd0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = dm_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_bus) state_nxt = BUSY;
            BUSY:    if (done)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_nxt = 1'b0;
        wreg_nxt  = 1'b0;
        wd_nxt    = '0;
        wdata_nxt = 32'd0;
        mis_nxt   = 1'b0;
        berr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !is_mem) begin
                    valid_nxt = 1'b1;
                    wreg_nxt  = wreg_i;
                    wd_nxt    = wd_i;
                    wdata_nxt = wdata_i;
                end else if (accept && misal) begin
                    valid_nxt = 1'b1;
                    wd_nxt    = wd_i;
                    mis_nxt   = 1'b1;
                end
            end
            BUSY: begin
                if (done && !flushed) begin
                    valid_nxt = 1'b1;
                    wd_nxt    = lat_wd;
                    if (dm_ack) begin
                        if (lat_is_load) begin
                            wreg_nxt  = lat_wreg;
                            wdata_nxt = ld_data;
                        end
                    end else begin
                        berr_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o    <= 1'b0;
            wreg_o     <= 1'b0;
            wd_o       <= '0;
            wdata_o    <= 32'd0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            valid_o    <= valid_nxt;
            wreg_o     <= wreg_nxt;
            wd_o       <= wd_nxt;
            wdata_o    <= wdata_nxt;
            misalign_o <= mis_nxt;
            bus_err_o  <= berr_nxt;
        end
    end

    // Bus request and latched operands; held untouched while dm_req is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_be     <= 4'd0;
            dm_wdata  <= 32'd0;
            lat_op    <= 4'd0;
            lat_lane  <= 2'd0;
            lat_wd    <= '0;
            lat_wreg  <= 1'b0;
            cnt       <= '0;
            flush_mem <= 1'b0;
        end else if (state == IDLE) begin
            if (start_bus) begin
                dm_req    <= 1'b1;
                dm_we     <= is_store;
                dm_addr   <= {mem_addr_i[AW-1:2], 2'b00};
                dm_be     <= st_be;
                dm_wdata  <= st_wdata;
                lat_op    <= mem_op_i;
                lat_lane  <= mem_addr_i[1:0];
                lat_wd    <= wd_i;
                lat_wreg  <= wreg_i;
                cnt       <= '0;
                flush_mem <= 1'b0;
            end
        end else if (done) begin
            dm_req    <= 1'b0;
            cnt       <= '0;
            flush_mem <= 1'b0;
        end else begin
            cnt <= cnt_inc;
            if (flush_i) flush_mem <= 1'b1;
        end
    end

endmodule

// File: doc/mem_stage_ls.md
MEM_STAGE_LS -- requirements
Module: mem_stage_ls

Interface
- REQ-001 Parameter: AW, default 32, data-memory address width.
- REQ-002 Parameter: RAW, default 5, register-address width (`RegAddrBus` equivalent).
- REQ-003 Parameter: TO_CYC, default 16, bus-timeout limit in cycles (>=2); counter width is $clog2(TO_CYC+1).
- REQ-004 Data width is fixed at 32 (`RegBus`); the byte-lane order is little-endian.
- REQ-005 Ports, clock and reset first: clk in 1 system clock; rst_n in 1 reset, asynchronous, active-low.
- REQ-006 Ports: valid_i in 1 EX result valid; ready_o out 1 stage can accept; flush_i in 1 squash.
- REQ-007 Ports: wdata_i in 32; wd_i in RAW; wreg_i in 1 (ALU result, destination, write enable).
- REQ-008 Ports: mem_op_i in 4 (0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; codes 9-15 are treated as NONE); mem_addr_i in AW; mem_sdata_i in 32.
- REQ-009 Ports: dm_req out 1; dm_we out 1; dm_addr out AW (word-aligned, bits [1:0]=0); dm_be out 4; dm_wdata out 32; dm_ack in 1; dm_rdata in 32.
- REQ-010 Ports: valid_o, wreg_o out 1; wd_o out RAW; wdata_o out 32; misalign_o, bus_err_o out 1; stall_req_o out 1.

Function
- REQ-011 State machine: IDLE, BUSY; ready_o = (state==IDLE); stall_req_o = (state==BUSY).
- REQ-012 All WB-side outputs are registered; wdata_o, wd_o and wreg_o are 0 whenever valid_o=0.
- REQ-013 IDLE, valid_i=1, NONE, flush_i=0: on the next edge valid_o=1 and wdata_o, wd_o, wreg_o equal the inputs (1-cycle latency).
- REQ-014 Misalign rule: LH/LHU/SH with addr[0]=1 is misaligned, as is LW/SW with addr[1:0]!=0.
- REQ-015 A misaligned op in IDLE issues no bus request; on the next edge valid_o=1, wreg_o=0, and misalign_o=1 for one cycle.
- REQ-016 An aligned memory op in IDLE latches its operands, moves to BUSY, and drives dm_req=1 from the next cycle; dm_we=1 for stores.
- REQ-017 dm_addr, dm_be, dm_wdata and dm_we hold stable while dm_req=1.
- REQ-018 Store lanes: SB gives be=1<<addr[1:0] and wdata={4{sdata[7:0]}}; SH gives be=addr[1]?4'b1100:4'b0011 and wdata={2{sdata[15:0]}}; SW gives be=4'b1111.
- REQ-019 Loads drive dm_be=4'b1111.
- REQ-020 BUSY with dm_ack=1: on that edge dm_req drops, state returns to IDLE, and valid_o=1.
- REQ-021 On a load completion, wdata_o holds the selected lane, sign-extended for LB/LH and zero-extended for LBU/LHU, and wreg_o=wreg_i as latched.
- REQ-022 On a store completion, wreg_o=0.
- REQ-023 Timeout: the counter clears on entering BUSY and increments each BUSY cycle without ack.
- REQ-024 When the counter reaches TO_CYC: dm_req drops, state returns to IDLE, valid_o=1, wreg_o=0, and bus_err_o=1 for one cycle.
- REQ-025 If dm_ack and the timeout occur in the same cycle, dm_ack wins.
- REQ-026 flush_i in IDLE discards the input, giving valid_o=0 next cycle.
- REQ-027 flush_i in BUSY does not drop dm_req; the transaction runs to ack or timeout but completes with valid_o=0, wreg_o=0, and no misalign_o or bus_err_o pulse.
- REQ-028 A flush_i seen at any point during BUSY is remembered until completion.
- REQ-029 valid_i while in BUSY is ignored, because ready_o=0 and the upstream stage holds its data.
- REQ-030 dm_ack while in IDLE is ignored.

Reset
- REQ-031 rst_n=0 immediately forces the following, independent of clk: state=IDLE; dm_req=0; dm_we=0; dm_addr=0; dm_be=0; dm_wdata=0.
- REQ-032 rst_n=0 immediately forces the following, independent of clk: valid_o=0; wreg_o=0; wd_o=0; wdata_o=0.
- REQ-033 rst_n=0 immediately forces the following, independent of clk: misalign_o=0; bus_err_o=0; timeout counter=0; flush memory=0.
- REQ-034 Reset asserted mid-transaction abandons it, and any late dm_ack after reset release is ignored.
- REQ-035 The first accept after reset occurs on the first clk edge with rst_n=1.

Verification
- REQ-036 Pass-through: NONE, wdata_i=0x1234_5678, wd_i=3, wreg_i=1 -> next cycle valid_o=1, wdata_o=0x1234_5678, wd_o=3, wreg_o=1.
- REQ-037 LB sign-extend: addr=0x103, dm_rdata=0x80AA_BBCC, ack after 2 cycles -> dm_be=4'hF, dm_addr=0x100, then wdata_o=0xFFFF_FF80; the same stimulus as LBU gives 0x0000_0080.
- REQ-038 SH at addr=0x22 with sdata=0xDEAD_BEEF -> dm_be=4'b1100, dm_wdata=0xBEEF_BEEF, dm_we=1; after ack, valid_o=1, wreg_o=0.
- REQ-039 Misaligned LW at addr=0x41 -> no dm_req; next cycle misalign_o=1, valid_o=1, wreg_o=0.
- REQ-040 Timeout: LW with no ack, TO_CYC=16 -> dm_req high for exactly 16 cycles, then bus_err_o pulses once and ready_o=1.
- REQ-041 Flush and reset mid-BUSY: flush_i pulse during BUSY then ack -> valid_o stays 0; rst_n low during BUSY -> dm_req=0 immediately with no clk edge, and all outputs read 0.
